// File: rtl/urv_dmem_responder.sv
// urv_dmem_responder
//   Responder side of the uRV data-memory interface. Requests are served from a
//   local word-organised RAM with a fixed number of wait states.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            synchronous reset, active-high
//   dm_addr_i        byte address; word index is [ADDR_WIDTH+1:2]
//   dm_data_s_i      store data, already lane-replicated
//   dm_data_select_i per-byte store enables
//   dm_load_i        load strobe
//   dm_store_i       store strobe (wins over load when both are high)
//   dm_ready_o       request can be accepted this cycle
//   dm_data_l_o      load data, updated with dm_load_done_o and then held
//   dm_load_done_o   one-cycle load completion pulse
//   dm_store_done_o  one-cycle store completion pulse
module urv_dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o
);

  localparam int          DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic {IDLE, BUSY} state_t;

  logic [31:0]           mem [DEPTH];
  state_t                state;
  logic [3:0]            cnt;
  logic                  pend_load;
  logic [31:0]           hold;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           rd_word;
  logic                  accept;
  logic                  is_load;
  logic                  unused_addr;

  assign idx     = dm_addr_i[ADDR_WIDTH+1:2];
  assign rd_word = mem[idx];
  assign accept  = (dm_load_i | dm_store_i) & dm_ready_o;
  // store has priority when both strobes are up
  assign is_load = dm_load_i & ~dm_store_i;

  // Upper address bits alias; low two bits are replaced by the lane selects.
  assign unused_addr = ^{dm_addr_i[31:ADDR_WIDTH+2], dm_addr_i[1:0]};

  // RAM: stores commit on the accept edge, so a reset that follows cannot
  // undo them and a load accepted next cycle sees the new data.
  always_ff @(posedge clk_i) begin
    if (accept && dm_store_i) begin
      for (int b = 0; b < 4; b++) begin
        if (dm_data_select_i[b]) mem[idx][8*b +: 8] <= dm_data_s_i[8*b +: 8];
      end
    end
  end

  // Load data is captured at accept; it is only exposed on dm_data_l_o
  // when the done pulse fires.
  always_ff @(posedge clk_i) begin
    if (accept && is_load) hold <= rd_word;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      cnt             <= '0;
      pend_load       <= 1'b0;
      dm_ready_o      <= 1'b1;
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      dm_data_l_o     <= '0;
    end else begin
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            pend_load <= is_load;
            if (WS == 4'd0) begin
              dm_load_done_o  <= is_load;
              dm_store_done_o <= dm_store_i;
              if (is_load) dm_data_l_o <= rd_word;
            end else begin
              state      <= BUSY;
              cnt        <= WS;
              dm_ready_o <= 1'b0;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          // leaving at cnt==1 makes the following cycle the done cycle,
          // with ready already high so the next request overlaps it
          if (cnt == 4'd1) begin
            state           <= IDLE;
            dm_ready_o      <= 1'b1;
            dm_load_done_o  <= pend_load;
            dm_store_done_o <= ~pend_load;
            if (pend_load) dm_data_l_o <= hold;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_urv_dmem_responder.sv
module tb_urv_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, data_s;
  logic [3:0]  sel;
  logic        ld, st;

  logic        r0, l0, s0, r3, l3, s3, r5, l5, s5;
  logic [31:0] d0, d3, d5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  urv_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u0 (
    .clk_i(clk), .rst_i(rst), .dm_addr_i(addr), .dm_data_s_i(data_s),
    .dm_data_select_i(sel), .dm_load_i(ld), .dm_store_i(st),
    .dm_ready_o(r0), .dm_data_l_o(d0), .dm_load_done_o(l0), .dm_store_done_o(s0));

  urv_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u3 (
    .clk_i(clk), .rst_i(rst), .dm_addr_i(addr), .dm_data_s_i(data_s),
    .dm_data_select_i(sel), .dm_load_i(ld), .dm_store_i(st),
    .dm_ready_o(r3), .dm_data_l_o(d3), .dm_load_done_o(l3), .dm_store_done_o(s3));

  urv_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(5)) u5 (
    .clk_i(clk), .rst_i(rst), .dm_addr_i(addr), .dm_data_s_i(data_s),
    .dm_data_select_i(sel), .dm_load_i(ld), .dm_store_i(st),
    .dm_ready_o(r5), .dm_data_l_o(d5), .dm_load_done_o(l5), .dm_store_done_o(s5));

  typedef struct {
    logic        ld, st;
    logic [31:0] addr, data;
    logic [3:0]  sel;
    logic        e_rdy, e_ld, e_st;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic l, logic s, logic [31:0] a, logic [31:0] d,
                              logic [3:0] se, logic er, logic el, logic es,
                              logic [31:0] ed);
    vec_t v;
    v.ld = l; v.st = s; v.addr = a; v.data = d; v.sel = se;
    v.e_rdy = er; v.e_ld = el; v.e_st = es; v.e_data = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ld = 0; st = 0; addr = 0; data_s = 0; sel = 0;
  endtask

  // leaves the caller at a negedge with reset released
  task automatic do_reset();
    @(negedge clk);
    rst = 1; idle_inputs();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    int n;
    rst = 1; idle_inputs();

    // Expected outputs are those seen in the cycle the vector is driven,
    // i.e. the result of the previous vector's request.
    vecs[0]  = mk(0,1,32'h10,  32'hDEADBEEF,4'hF, 1,0,0, 32'h0);
    vecs[1]  = mk(1,0,32'h10,  32'h0,       4'h0, 1,0,1, 32'h0);
    vecs[2]  = mk(0,1,32'h10,  32'h0,       4'hF, 1,1,0, 32'hDEADBEEF);
    vecs[3]  = mk(0,1,32'h10,  32'hABABABAB,4'h4, 1,0,1, 32'hDEADBEEF);
    vecs[4]  = mk(1,0,32'h10,  32'h0,       4'h0, 1,0,1, 32'hDEADBEEF);
    vecs[5]  = mk(0,1,32'h10,  32'h12341234,4'h3, 1,1,0, 32'h00AB0000);
    vecs[6]  = mk(1,0,32'h10,  32'h0,       4'h0, 1,0,1, 32'h00AB0000);
    vecs[7]  = mk(0,1,32'h1004,32'h11111111,4'hF, 1,1,0, 32'h00AB1234);
    vecs[8]  = mk(1,0,32'h2004,32'h0,       4'h0, 1,0,1, 32'h00AB1234);
    vecs[9]  = mk(1,1,32'h20,  32'h55AA55AA,4'hF, 1,1,0, 32'h11111111);
    vecs[10] = mk(1,0,32'h20,  32'h0,       4'h0, 1,0,1, 32'h11111111);
    vecs[11] = mk(0,1,32'h30,  32'h77777777,4'hF, 1,1,0, 32'h55AA55AA);
    vecs[12] = mk(0,1,32'h33,  32'hFFFFFFFF,4'h0, 1,0,1, 32'h55AA55AA);
    vecs[13] = mk(1,0,32'h30,  32'h0,       4'h0, 1,0,1, 32'h55AA55AA);
    vecs[14] = mk(0,0,32'h0,   32'h0,       4'h0, 1,1,0, 32'h77777777);
    vecs[15] = mk(0,0,32'h0,   32'h0,       4'h0, 1,0,0, 32'h77777777);

    do_reset();
    chk("reset_u0", {r0, l0, s0, d0}, {1'b1, 1'b0, 1'b0, 32'h0});
    chk("reset_u5", {r5, l5, s5, d5}, {1'b1, 1'b0, 1'b0, 32'h0});

    // ---- zero-wait table: RAW, byte lanes, aliasing, dual strobe, sel=0
    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge clk);
      chk($sformatf("vec%0d", i), {r0, l0, s0, d0},
          {vecs[i].e_rdy, vecs[i].e_ld, vecs[i].e_st, vecs[i].e_data});
      ld = vecs[i].ld; st = vecs[i].st; addr = vecs[i].addr;
      data_s = vecs[i].data; sel = vecs[i].sel;
    end

    // ---- WAIT_STATES=3: latency, ready shape, held back-to-back load
    do_reset();
    st = 1; addr = 32'h40; data_s = 32'hA5A5A5A5; sel = 4'hF;
    @(negedge clk);
    idle_inputs();
    n = 0;
    while (!s3 && n < 20) begin @(negedge clk); n++; end
    chk("w3_store_latency", 64'(n), 64'd3);
    @(negedge clk);
    chk("w3_idle_ready", {r3, l3, s3}, 3'b100);
    ld = 1; addr = 32'h40;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("w3_cyc%0d", c), {r3, l3, s3},
          {!((c >= 1 && c <= 3) || (c >= 5 && c <= 7)), (c == 4 || c == 8), 1'b0});
      if (c == 4 || c == 8) chk($sformatf("w3_data%0d", c), d3, 32'hA5A5A5A5);
      if (c == 5) ld = 0;
    end

    // ---- WAIT_STATES=5: reset mid-store aborts done but keeps data
    do_reset();
    chk("w5_ready_before", r5, 1'b1);
    st = 1; addr = 32'h80; data_s = 32'hCAFEF00D; sel = 4'hF;
    @(negedge clk);
    idle_inputs();
    chk("w5_busy", r5, 1'b0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("w5_after_reset", {r5, l5, s5}, 3'b100);
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (s5 || l5) n++;
      @(negedge clk);
    end
    chk("w5_no_done_after_abort", 64'(n), 64'd0);
    ld = 1; addr = 32'h80;
    @(negedge clk);
    ld = 0;
    n = 0;
    while (!l5 && n < 20) begin @(negedge clk); n++; end
    chk("w5_load_latency", 64'(n), 64'd5);
    chk("w5_load_data", {s5, d5}, {1'b0, 32'hCAFEF00D});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/urv_dmem_responder.md
Name: urv_dmem_responder

Overview:
Responder end of the uRV data-memory interface. It accepts load/store requests that the execute stage issues on dm_addr/dm_data_s/dm_data_select/dm_load/dm_store, qualified by dm_ready. It serves them from a local word-organised RAM with a programmable number of wait states. Load data and load/store completion strobes go back to the writeback stage.

Parameters:
ADDR_WIDTH, 10, word-address bits; RAM holds 2^ADDR_WIDTH 32-bit words (default 4 KiB).
WAIT_STATES, 0, extra busy cycles per access; legal range 0..15.

Ports:
clk_i  input  1  clock; all logic on the rising edge.
rst_i  input  1  synchronous reset, active-high.
dm_addr_i  input  32  byte address of the request.
dm_data_s_i  input  32  store data, already lane-replicated by the core.
dm_data_select_i  input  4  byte-lane enables for stores; bit n enables data[8n+7:8n].
dm_load_i  input  1  load request strobe.
dm_store_i  input  1  store request strobe.
dm_ready_o  output  1  responder can accept a request this cycle.
dm_data_l_o  output  32  load data word; valid when dm_load_done_o=1.
dm_load_done_o  output  1  one-cycle pulse: load complete.
dm_store_done_o  output  1  one-cycle pulse: store complete.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous, active-high.
- Reset values: dm_ready_o=1, dm_load_done_o=0, dm_store_done_o=0, dm_data_l_o=0. FSM goes to IDLE and the wait counter to 0. RAM contents are not cleared.
- Accept: a request is accepted on any cycle where (dm_load_i|dm_store_i) & dm_ready_o. Strobes with dm_ready_o=0 are ignored; the core withdraws them while stalled.
- Simultaneous load and store: treated as a store only. Only dm_store_done_o is pulsed.
- Addressing: word index = dm_addr_i[ADDR_WIDTH+1:2]. Bits [1:0] are ignored (lane choice comes from select). Bits above ADDR_WIDTH+1 are ignored, so upper addresses alias.
- Store commit: RAM lanes are written on the clock edge that ends the accept cycle. Only lanes with select=1 are written. Select=4'b0000 writes nothing but still completes.
- Load read: the array is read on the accept edge into a holding register. This gives read-after-write ordering: a store accepted at T followed by a load accepted at T+1 or later returns the new data.
- Latency: for an accept at cycle T, the done pulse occurs at T+1+WAIT_STATES.
- Load data: dm_data_l_o is updated together with dm_load_done_o and then holds its value until the next load completes.
- FSM states:
  - IDLE: dm_ready_o=1. An accept with WAIT_STATES=0 stays in IDLE and pulses done next cycle. An accept with WAIT_STATES>0 loads the counter with WAIT_STATES and goes to BUSY.
  - BUSY: dm_ready_o=0. Counter decrements each cycle. When the counter reaches 1, go to IDLE; the next cycle is the done cycle.
  - Done cycle: dm_ready_o=1 is registered, so a new request may be accepted in the same cycle its predecessor's done is pulsed.
- Throughput: with WAIT_STATES=0, back-to-back requests are accepted every cycle at one completion per cycle. With WAIT_STATES=W, at most one request per W+1 cycles.
- Done pulses are exactly one cycle wide, and load_done and store_done are never high together.
- Reset mid-operation: the pending transaction is aborted with no done pulse. A store is already committed, because commit happens at accept. dm_ready_o=1 in the first cycle after reset deasserts.
- Cover/assert: dm_ready_o=0 exactly during BUSY. Number of done pulses equals number of accepts, apart from accepts cut off by reset.

Test Plan:
1. WAIT_STATES=0: store 0xDEADBEEF, select 4'b1111, addr 0x10 at T; load addr 0x10 at T+1 -> store_done at T+1; load_done at T+2 with data_l=0xDEADBEEF; ready high throughout.
2. Byte lanes: word 0x10 = 0x00000000; store data 0xABABABAB, select 4'b0100 -> load returns 0x00AB0000. Then store 0x12341234, select 4'b0011 -> load returns 0x00AB1234.
3. WAIT_STATES=3: load accepted at T -> ready=0 at T+1..T+3, load_done at T+4. A second load held asserted is accepted at T+4 and completes at T+8.
4. Aliasing with ADDR_WIDTH=10: store 0x11111111 to 0x00001004, then load 0x00002004 -> returns 0x11111111.
5. Both strobes high with select 4'b1111, data 0x55AA55AA -> only store_done pulses; a subsequent load returns 0x55AA55AA.
6. WAIT_STATES=5: store of 0xCAFEF00D accepted, rst_i asserted 2 cycles later for one cycle -> no store_done, ready=1 after reset, memory holds 0xCAFEF00D.
